seg_scan_driver: RTL



---
 rtl/seg_scan_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Register-block side bus of the multiplexed 7-segment driver.
// master: load/value/dp/blank_mask/blink_mask/lzs_en out; pending/frame_done in.
// slave : the same signals with directions reversed (driver side).
interface seg_scan_if #(
    parameter int NDIGITS = 8
);
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp;
    logic [NDIGITS-1:0]     blank_mask;
    logic [NDIGITS-1:0]     blink_mask;
    logic                   lzs_en;
    logic                   pending;
    logic                   frame_done;

    modport master (
        output load, value, dp, blank_mask, blink_mask, lzs_en,
        input  pending, frame_done
    );

    modport slave (
        input  load, value, dp, blank_mask, blink_mask, lzs_en,
        output pending, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed NDIGITS hex 7-segment driver with dp, blanking, blink,
// leading-zero suppression and frame-aligned (tear-free) updates.
// Ports: clk, rst (sync, active-high); bus (seg_scan_if.slave: load bus in,
// pending/frame_done out); an (one-hot digit enable), seg {g..a}, seg_dp.
module seg_scan_driver #(
    parameter int NDIGITS      = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_if.slave          bus,
    output logic [NDIGITS-1:0] an,
    output logic [6:0]         seg,
    output logic               seg_dp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam bit INV = (ACTIVE_LOW != 0);
    localparam logic [NDIGITS-1:0] AN_OFF = INV ? '1 : '0;
    localparam logic [6:0] SEG_OFF = INV ? 7'h7F : 7'h00;
    localparam logic DP_OFF = INV;

    // vld marks contents that came from a load; cleared contents stay dark.
    typedef struct packed {
        logic [4*NDIGITS-1:0] value;
        logic [NDIGITS-1:0]   dp;
        logic [NDIGITS-1:0]   blank;
        logic [NDIGITS-1:0]   blink;
        logic                 lzs;
        logic                 vld;
    } cfg_t;

    logic [DW-1:0]      div_q, div_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BW-1:0]      fcnt_q, fcnt_d;
    logic               phase_q, phase_d;
    cfg_t               pend_q, pend_d;
    cfg_t               act_q, act_d;
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;
    logic [NDIGITS-1:0] an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               seg_dp_q, seg_dp_d;

    cfg_t               in_cfg;
    logic               scan_end;
    logic               last_dig;
    logic               boundary;
    logic [NDIGITS-1:0] supp;
    logic [3:0]         dig;
    logic               dark;
    logic [6:0]         seg_on;
    logic               dp_on;
    logic [NDIGITS-1:0] an_on;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        glyph = 7'h00;
        unique case (h)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            4'hF: glyph = 7'b1110001;
        endcase
    endfunction

    always_comb begin
        in_cfg = '{value: bus.value, dp: bus.dp, blank: bus.blank_mask,
                   blink: bus.blink_mask, lzs: bus.lzs_en, vld: 1'b1};

        scan_end = (div_q == DW'(SCAN_DIV - 1));
        last_dig = (idx_q == IW'(NDIGITS - 1));
        boundary = scan_end && last_dig;

        div_d = scan_end ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (scan_end) begin
            idx_d = last_dig ? '0 : idx_q + 1'b1;
        end

        pend_d    = bus.load ? in_cfg : pend_q;
        pending_d = pending_q | bus.load;
        act_d     = act_q;
        fcnt_d    = fcnt_q;
        phase_d   = phase_q;

        // A load in the boundary cycle bypasses the pending stage.
        if (boundary) begin
            pending_d = 1'b0;
            if (bus.load) begin
                act_d = in_cfg;
            end else if (pending_q) begin
                act_d = pend_q;
            end
            if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        frame_done_d = boundary;

        // Digit i is a leading zero when every digit from i upward is 0.
        supp = '0;
        for (int i = 1; i < NDIGITS; i++) begin
            supp[i] = act_q.lzs && ((act_q.value >> (4 * i)) == '0);
        end

        dig    = act_q.value[{idx_q, 2'b00} +: 4];
        dark   = !act_q.vld || act_q.blank[idx_q]
               || (act_q.blink[idx_q] && phase_q);
        seg_on = (dark || supp[idx_q]) ? 7'h00 : glyph(dig);
        dp_on  = !dark && act_q.dp[idx_q];
        an_on  = '0;
        an_on[idx_q] = 1'b1;

        an_d     = INV ? ~an_on : an_on;
        seg_d    = INV ? ~seg_on : seg_on;
        seg_dp_d = INV ? ~dp_on : dp_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            pend_q       <= '0;
            act_q        <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= DP_OFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
        end
    end

    assign an             = an_q;
    assign seg            = seg_q;
    assign seg_dp         = seg_dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
endmodule
